// File: rtl/interrupt_sequencer.sv
// Interrupt sequencer: raises irq for the controller's pending vector and, once
// the CPU acknowledges, clears that vector's status bit with a read-modify-write
// on the interrupt-controller port, then waits for iret before taking another.
// The CPU register port is forwarded to the controller whenever the sequencer
// does not own it.
module interrupt_sequencer (
   input  logic       clk,
   input  logic       rst,
   input  logic       cpu_ce,
   input  logic       cpu_wren,
   input  logic       cpu_addr,
   input  logic [7:0] cpu_wdata,
   output logic [7:0] cpu_rdata,
   output logic       cpu_ready,
   output logic       ic_ce,
   output logic       ic_wren,
   output logic       ic_addr,
   output logic [7:0] ic_wdata,
   input  logic [7:0] ic_rdata,
   input  logic       ic_int_rq,
   input  logic [2:0] ic_int_addr,
   output logic       irq,
   output logic [2:0] vector,
   input  logic       irq_ack,
   input  logic       iret,
   output logic       busy
);

   typedef enum logic [2:0] {
      StIdle,
      StPend,
      StRd,
      StRdw,
      StWr,
      StSettle,
      StActive
   } state_e;

   state_e     state_q, state_d;
   logic [2:0] vector_q, vector_d;
   logic [7:0] snap_q, snap_d;
   logic [1:0] cnt_q, cnt_d;

   // State, latched vector, status snapshot and settle counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         vector_q <= 3'd0;
         snap_q   <= 8'h00;
         cnt_q    <= 2'd0;
      end else begin
         state_q  <= state_d;
         vector_q <= vector_d;
         snap_q   <= snap_d;
         cnt_q    <= cnt_d;
      end
   end

   // Next-state: request -> pend -> read/modify/write status -> settle -> active
   always_comb begin
      state_d  = state_q;
      vector_d = vector_q;
      snap_d   = snap_q;
      cnt_d    = 2'd0;
      case (state_q)
         StIdle: begin
            if (ic_int_rq) begin
               state_d  = StPend;
               vector_d = ic_int_addr;
            end
         end
         StPend: begin
            // Acknowledge wins over a request that drops in the same cycle
            if (irq_ack) begin
               state_d = StRd;
            end else if (!ic_int_rq) begin
               state_d = StIdle;
            end
         end
         StRd: begin
            state_d = StRdw;
         end
         StRdw: begin
            // Controller read data is registered, so it is valid in this cycle
            snap_d  = ic_rdata;
            state_d = StWr;
         end
         StWr: begin
            state_d = StSettle;
         end
         StSettle: begin
            // Two cycles let the controller's registered request see the write
            if (cnt_q == 2'd1) begin
               state_d = StActive;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         StActive: begin
            if (iret) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Port ownership: sequencer drives the controller in RD/RDW/WR, else CPU passes through
   always_comb begin
      busy     = 1'b0;
      ic_ce    = cpu_ce;
      ic_wren  = cpu_wren;
      ic_addr  = cpu_addr;
      ic_wdata = cpu_wdata;
      case (state_q)
         StRd: begin
            busy     = 1'b1;
            ic_ce    = 1'b1;
            ic_wren  = 1'b0;
            ic_addr  = 1'b0;
            ic_wdata = 8'h00;
         end
         StRdw: begin
            busy     = 1'b1;
            ic_ce    = 1'b0;
            ic_wren  = 1'b0;
            ic_addr  = 1'b0;
            ic_wdata = 8'h00;
         end
         StWr: begin
            busy     = 1'b1;
            ic_ce    = 1'b1;
            ic_wren  = 1'b1;
            ic_addr  = 1'b0;
            ic_wdata = snap_q & ~(8'h01 << vector_q);
         end
         default: begin
         end
      endcase
   end

   assign irq       = (state_q == StPend);
   assign vector    = vector_q;
   assign cpu_ready = ~busy;
   assign cpu_rdata = ic_rdata;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Bench for interrupt_sequencer: a small interrupt-controller model, a cycle-age
// reference model of the sequencer, a per-cycle compare process, directed
// scenarios with literal expectations, then a randomized phase.
module tb_interrupt_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       cpu_ce, cpu_wren, cpu_addr;
   logic [7:0] cpu_wdata;
   logic [7:0] cpu_rdata;
   logic       cpu_ready;
   logic       ic_ce, ic_wren, ic_addr;
   logic [7:0] ic_wdata;
   logic [7:0] ic_rdata    = 8'h00;
   logic       ic_int_rq   = 1'b0;
   logic [2:0] ic_int_addr = 3'd0;
   logic       irq;
   logic [2:0] vector;
   logic       irq_ack, iret;
   logic       busy;

   // Interrupt-controller model state; inj sets status bits from "peripherals"
   logic [7:0] ic_status = 8'h00;
   logic [7:0] ic_ctrl   = 8'h00;
   logic [7:0] inj;

   // Reference model: m_age counts edges since the accepted ack (-1 = not servicing)
   logic       m_pend = 1'b0;
   int         m_age  = -1;
   logic [2:0] m_vec  = 3'd0;
   logic [7:0] m_snap = 8'h00;
   logic       e_busy;

   int n_cmp = 0;
   int n_bad = 0;

   interrupt_sequencer dut (
      .clk         (clk),
      .rst         (rst),
      .cpu_ce      (cpu_ce),
      .cpu_wren    (cpu_wren),
      .cpu_addr    (cpu_addr),
      .cpu_wdata   (cpu_wdata),
      .cpu_rdata   (cpu_rdata),
      .cpu_ready   (cpu_ready),
      .ic_ce       (ic_ce),
      .ic_wren     (ic_wren),
      .ic_addr     (ic_addr),
      .ic_wdata    (ic_wdata),
      .ic_rdata    (ic_rdata),
      .ic_int_rq   (ic_int_rq),
      .ic_int_addr (ic_int_addr),
      .irq         (irq),
      .vector      (vector),
      .irq_ack     (irq_ack),
      .iret        (iret),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [2:0] lowest_set(input logic [7:0] v);
      lowest_set = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (v[i]) lowest_set = 3'(i);
      end
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Controller: registered reads, registered request; lowest enabled bit has priority
   always @(posedge clk) begin
      if (ic_ce && ic_wren && !ic_addr) ic_status <= ic_wdata | inj;
      else ic_status <= ic_status | inj;
      if (ic_ce && ic_wren && ic_addr) ic_ctrl <= ic_wdata;
      if (ic_ce && !ic_wren) ic_rdata <= ic_addr ? ic_ctrl : ic_status;
      ic_int_rq   <= |(ic_status & ic_ctrl);
      ic_int_addr <= lowest_set(ic_status & ic_ctrl);
   end

   // Sequencer reference: pending flag plus age of the current service
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_pend <= 1'b0;
         m_age  <= -1;
         m_vec  <= 3'd0;
         m_snap <= 8'h00;
      end else begin
         if (m_age == 1) m_snap <= ic_rdata;
         if (m_age >= 5) begin
            if (iret) m_age <= -1;
         end else if (m_age >= 0) begin
            m_age <= m_age + 1;
         end else if (m_pend) begin
            if (irq_ack) begin
               m_pend <= 1'b0;
               m_age  <= 0;
            end else if (!ic_int_rq) begin
               m_pend <= 1'b0;
            end
         end else if (ic_int_rq) begin
            m_pend <= 1'b1;
            m_vec  <= ic_int_addr;
         end
      end
   end

   // Per-cycle compare, mid-way through the low phase
   always @(negedge clk) begin
      #2;
      e_busy = (m_age >= 0) && (m_age <= 2);
      check("irq", irq, m_pend);
      check("vector", vector, m_vec);
      check("busy", busy, e_busy);
      check("cpu_ready", cpu_ready, !e_busy);
      check("cpu_rdata", cpu_rdata, ic_rdata);
      if (!e_busy) begin
         check("fwd_ce", ic_ce, cpu_ce);
         check("fwd_wren", ic_wren, cpu_wren);
         check("fwd_addr", ic_addr, cpu_addr);
         check("fwd_wdata", ic_wdata, cpu_wdata);
      end else if (m_age == 0) begin
         check("rd_ce", ic_ce, 1'b1);
         check("rd_wren", ic_wren, 1'b0);
         check("rd_addr", ic_addr, 1'b0);
      end else if (m_age == 1) begin
         check("rdw_ce", ic_ce, 1'b0);
      end else begin
         check("wr_ce", ic_ce, 1'b1);
         check("wr_wren", ic_wren, 1'b1);
         check("wr_addr", ic_addr, 1'b0);
         check("wr_wdata", ic_wdata, m_snap & ~(8'h01 << m_vec));
      end
   end

   // CPU write held until accepted; entered and left on a falling edge
   task automatic cpu_write(input logic a, input logic [7:0] d);
      int n;
      cpu_ce = 1'b1; cpu_wren = 1'b1; cpu_addr = a; cpu_wdata = d;
      n = 0;
      #1;
      while (!cpu_ready && n < 20) begin
         @(negedge clk); #1; n++;
      end
      check("cpu_accept", cpu_ready, 1'b1);
      @(negedge clk);
      cpu_ce = 1'b0; cpu_wren = 1'b0;
   endtask

   task automatic wait_irq(input string name);
      int n;
      n = 0;
      while (!irq && n < 20) begin
         @(negedge clk); n++;
      end
      check(name, irq, 1'b1);
   endtask

   task automatic serve();
      wait_irq("serve_irq");
      irq_ack = 1'b1;
      @(negedge clk); irq_ack = 1'b0;
      repeat (5) @(negedge clk);
      iret = 1'b1;
      @(negedge clk); iret = 1'b0;
   endtask

   initial begin : stim
      int n;
      logic rdy_prev;
      rst = 1'b1; cpu_ce = 1'b0; cpu_wren = 1'b0; cpu_addr = 1'b0; cpu_wdata = 8'h00;
      irq_ack = 1'b0; iret = 1'b0; inj = 8'h00;

      // Reset state and forwarding while in reset
      repeat (3) @(negedge clk);
      cpu_ce = 1'b1; cpu_addr = 1'b1; cpu_wdata = 8'hA5;
      #1;
      check("rst_irq", irq, 1'b0);
      check("rst_vector", vector, 3'd0);
      check("rst_busy", busy, 1'b0);
      check("rst_ready", cpu_ready, 1'b1);
      check("rst_fwd", ic_wdata, 8'hA5);
      @(negedge clk); cpu_ce = 1'b0;
      @(negedge clk); rst = 1'b0;

      // Vector 5 with status 0x24 (bit 2 masked); CPU control write stalled by RD..WR
      cpu_write(1'b1, 8'h20);
      inj = 8'h24;
      @(negedge clk); inj = 8'h00;
      n = 0;
      while (!ic_int_rq && n < 10) begin
         @(negedge clk); n++;
      end
      check("s1_rq", ic_int_rq, 1'b1);
      @(negedge clk); #1;
      check("s1_irq", irq, 1'b1);
      check("s1_vector", vector, 3'd5);
      irq_ack = 1'b1;
      @(negedge clk); irq_ack = 1'b0;
      cpu_ce = 1'b1; cpu_wren = 1'b1; cpu_addr = 1'b1; cpu_wdata = 8'hFF;
      #1;
      check("s1_rd_ready", cpu_ready, 1'b0);
      check("s1_rd_ce", ic_ce, 1'b1);
      check("s1_rd_wren", ic_wren, 1'b0);
      check("s1_rd_irq", irq, 1'b0);
      @(negedge clk); #1;
      check("s1_rdw_ready", cpu_ready, 1'b0);
      check("s1_rdw_ce", ic_ce, 1'b0);
      @(negedge clk); #1;
      check("s1_wr_ready", cpu_ready, 1'b0);
      check("s1_wr_wren", ic_wren, 1'b1);
      check("s1_wr_addr", ic_addr, 1'b0);
      check("s1_wr_wdata", ic_wdata, 8'h04);
      @(negedge clk); #1;
      check("s2_ready", cpu_ready, 1'b1);
      check("s2_ce", ic_ce, 1'b1);
      check("s2_wren", ic_wren, 1'b1);
      check("s2_addr", ic_addr, 1'b1);
      check("s2_wdata", ic_wdata, 8'hFF);
      @(negedge clk); cpu_ce = 1'b0; cpu_wren = 1'b0;
      #1;
      check("s1_status", ic_status, 8'h04);
      check("s2_ctrl", ic_ctrl, 8'hFF);
      @(negedge clk);
      cpu_write(1'b0, 8'h00);
      iret = 1'b1;
      @(negedge clk); iret = 1'b0;

      // Stray ack/iret in IDLE have no effect
      irq_ack = 1'b1; iret = 1'b1;
      @(negedge clk); irq_ack = 1'b0; iret = 1'b0;
      #1;
      check("s4_busy", busy, 1'b0);
      check("s4_irq", irq, 1'b0);
      @(negedge clk);

      // Request withdrawn in PEND without ack
      inj = 8'h02;
      @(negedge clk); inj = 8'h00;
      wait_irq("s3_irq");
      cpu_write(1'b0, 8'h00);
      n = 0;
      while (ic_int_rq && n < 10) begin
         @(negedge clk); n++;
      end
      #1;
      check("s3_still_pend", irq, 1'b1);
      @(negedge clk); #1;
      check("s3_irq_drop", irq, 1'b0);
      check("s3_busy", busy, 1'b0);
      @(negedge clk);

      // Two pending bits: vector 0 first; iret only honoured once ACTIVE
      inj = 8'h09;
      @(negedge clk); inj = 8'h00;
      wait_irq("s6_irq0");
      #1;
      check("s6_vec0", vector, 3'd0);
      irq_ack = 1'b1;
      @(negedge clk); irq_ack = 1'b0;
      @(negedge clk);
      @(negedge clk); #1;
      check("s6_wr0_wren", ic_wren, 1'b1);
      check("s6_wr0_wdata", ic_wdata, 8'h08);
      @(negedge clk);
      @(negedge clk); iret = 1'b1;
      @(negedge clk); #1;
      check("s6_n6_irq", irq, 1'b0);
      @(negedge clk); iret = 1'b0;
      #1;
      check("s6_n7_irq", irq, 1'b0);
      @(negedge clk); #1;
      check("s6_irq3", irq, 1'b1);
      check("s6_vec3", vector, 3'd3);
      irq_ack = 1'b1;
      @(negedge clk); irq_ack = 1'b0;
      @(negedge clk);
      @(negedge clk); #1;
      check("s6_wr3_wren", ic_wren, 1'b1);
      check("s6_wr3_wdata", ic_wdata, 8'h00);
      repeat (3) @(negedge clk);
      iret = 1'b1;
      @(negedge clk); iret = 1'b0;
      #1;
      check("s6_status", ic_status, 8'h00);

      // Reset during RDW aborts without a controller write
      @(negedge clk);
      inj = 8'h10;
      @(negedge clk); inj = 8'h00;
      wait_irq("s5_irq");
      irq_ack = 1'b1;
      @(negedge clk); irq_ack = 1'b0;
      @(negedge clk); rst = 1'b1;
      #1;
      check("s5_busy", busy, 1'b0);
      check("s5_irq", irq, 1'b0);
      check("s5_ready", cpu_ready, 1'b1);
      check("s5_wren", ic_wren, 1'b0);
      check("s5_vector", vector, 3'd0);
      @(negedge clk);
      @(negedge clk); #1;
      check("s5_status", ic_status, 8'h10);
      @(negedge clk); rst = 1'b0;
      serve();
      #1;
      check("s5_cleared", ic_status, 8'h00);

      // Randomized traffic; a stalled CPU access is held until accepted
      rdy_prev = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         if (!(cpu_ce && !rdy_prev)) begin
            cpu_ce    = ($urandom_range(0, 3) == 0);
            cpu_wren  = 1'($urandom_range(0, 1));
            cpu_addr  = 1'($urandom_range(0, 1));
            cpu_wdata = 8'($urandom);
         end
         inj     = ($urandom_range(0, 7) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
         irq_ack = ($urandom_range(0, 2) == 0);
         iret    = ($urandom_range(0, 4) == 0);
         rst     = ($urandom_range(0, 399) == 0);
         #1 rdy_prev = cpu_ready;
      end

      @(negedge clk);
      rst = 1'b0; cpu_ce = 1'b0; cpu_wren = 1'b0; irq_ack = 1'b0; iret = 1'b0; inj = 8'h00;
      repeat (3) @(negedge clk);
      #3;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/interrupt_sequencer.md
INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

Interface
REQ-001 Ports SHALL be (clock and reset first):
- clk  in  1  single system clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_ce  in  1  CPU register-port select.
- cpu_wren  in  1  CPU write enable.
- cpu_addr  in  1  CPU register select (1 = control, 0 = status).
- cpu_wdata  in  8  CPU write data.
- cpu_rdata  out  8  read data returned to the CPU.
- cpu_ready  out  1  CPU access accepted this cycle.
- ic_ce  out  1  interrupt-controller select.
- ic_wren  out  1  interrupt-controller write enable.
- ic_addr  out  1  interrupt-controller register select.
- ic_wdata  out  8  interrupt-controller write data.
- ic_rdata  in  8  interrupt-controller registered read data.
- ic_int_rq  in  1  interrupt-controller request.
- ic_int_addr  in  3  interrupt-controller highest-priority vector.
- irq  out  1  interrupt request to the CPU.
- vector  out  3  latched vector presented with irq.
- irq_ack  in  1  CPU accepts the interrupt (1-cycle pulse).
- iret  in  1  CPU finished the service routine (1-cycle pulse).
- busy  out  1  sequencer owns the interrupt-controller port.
REQ-002 There SHALL be one clock (clk); reset (rst) SHALL be asynchronous and active-high.

Function
REQ-003 The FSM SHALL have states IDLE, PEND, RD, RDW, WR, SETTLE and ACTIVE.
REQ-004 IDLE -> PEND when ic_int_rq=1; on that edge vector SHALL latch ic_int_addr, and vector SHALL then hold until the next PEND entry.
REQ-005 irq SHALL be 1 exactly in PEND.
REQ-006 In PEND:
- irq_ack=1 -> RD.
- else ic_int_rq=0 -> IDLE (request withdrawn).
- irq_ack SHALL win over a simultaneous ic_int_rq fall.
REQ-007 RD SHALL drive ic_ce=1, ic_wren=0, ic_addr=0 (status read) -> RDW.
REQ-008 RDW SHALL drive ic_ce=0 and capture ic_rdata into an internal snapshot at the closing edge -> WR.
REQ-009 WR SHALL drive ic_ce=1, ic_wren=1, ic_addr=0, ic_wdata = snapshot with bit[vector] cleared, all other bits unchanged -> SETTLE.
REQ-010 SETTLE SHALL last exactly 2 cycles (2-bit counter) so that the registered ic_int_rq reflects the write -> ACTIVE.
REQ-011 ACTIVE -> IDLE on iret=1; irq_ack outside PEND and iret outside ACTIVE SHALL be ignored; there is no nesting.
REQ-012 busy SHALL be 1 in RD, RDW and WR only.
REQ-013 cpu_ready SHALL equal ~busy (combinational).
REQ-014 When busy=0, ic_ce/ic_wren/ic_addr/ic_wdata SHALL pass cpu_ce/cpu_wren/cpu_addr/cpu_wdata combinationally.
REQ-015 When busy=1, CPU signals SHALL be blocked and the CPU SHALL hold its access until cpu_ready=1; no CPU access is lost or duplicated.
REQ-016 cpu_rdata SHALL equal ic_rdata combinationally; CPU read data is valid the cycle after an accepted read, matching the controller's registered read.
REQ-017 Total ack-to-clear latency SHALL be 3 cycles (RD, RDW, WR); ACTIVE SHALL be reached 5 cycles after the irq_ack edge.
REQ-018 If the snapshot bit[vector] is already 0, WR SHALL still occur (idempotent write).

Reset
REQ-019 While rst=1:
- State SHALL be IDLE.
- irq=0, vector=0, busy=0, snapshot=0, SETTLE counter=0.
- Forwarding path active (cpu_ready=1).
REQ-020 rst asserted in any state, including RD/RDW/WR, SHALL abort immediately with no further ic write; after rst deasserts, the FSM SHALL start in IDLE.

Verification
REQ-021 A bench SHALL cover the following scenarios:
- ic_int_rq=1, ic_int_addr=5, status reads 0x24; irq_ack -> irq=1 with vector=5 one cycle after request; ic writes status 0x04 exactly 3 cycles after ack; ACTIVE 5 cycles after ack.
- CPU write to control (0xFF) held during RD..WR -> cpu_ready=0 for 3 cycles; write reaches ic unchanged on the first cycle busy=0.
- ic_int_rq falls in PEND without ack -> irq=0 next cycle, IDLE, no ic access.
- irq_ack and iret pulsed in IDLE/ACTIVE out of sequence -> no state change except iret in ACTIVE -> IDLE.
- rst asserted during RDW -> irq/busy=0 immediately, no ic_wren pulse, cpu_ready=1.
- Two pending bits (0,3): service vector 0, iret, then vector 3 served, with status ending 0x00.
